branch_ctrl: RTL and testbench
==============================

BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 Parameter: MAX_WAIT, default 4, maximum consecutive operand-wait cycles before abort; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 BrValid  input  1  decode stage presents a conditional branch.
REQ-005 BrType  input  1  branch type: 0=BEQ (taken if Rs==Rt), 1=BNE (taken if Rs!=Rt).
REQ-006 BrTarget  input  32  branch target address.
REQ-007 RsReady, RtReady  input  1 each  operand valid; no pending producer.
REQ-008 RsData, RtData  input  32 each  operand values; meaningful only while the matching Ready is high.
REQ-009 ExFlush  input  1  pipeline squash (exception or older redirect); highest priority.
REQ-010 BrAccept  output  1  controller is idle and able to capture a branch.
REQ-011 StallID  output  1  hold the decode stage.
REQ-012 PCSel  output  1  select PCTarget as next PC; single-cycle pulse.
REQ-013 FlushIF  output  1  squash the fetch stage; single-cycle pulse, coincident with PCSel.
REQ-014 PCTarget  output  32  redirect address.
REQ-015 TakenCount, ResolvedCount  output  16 each  statistics counters.
REQ-016 ErrTimeout  output  1  sticky operand-wait timeout flag.

Function
REQ-017 FSM states SHALL be IDLE, WAIT_OPS, RESOLVE and REDIRECT; all outputs except the counters and ErrTimeout SHALL be Moore-decoded from the state.
REQ-018 IDLE: BrAccept=1 and StallID=0.
  - BrValid=1 with RsReady&RtReady=1: capture BrType, BrTarget, RsData and RtData; next state RESOLVE.
  - BrValid=1 with either Ready=0: capture BrType and BrTarget; clear the wait counter; next state WAIT_OPS.
REQ-019 WAIT_OPS: StallID=1. Each cycle:
  - RsReady&RtReady=1: capture RsData and RtData; next state RESOLVE.
  - Otherwise: increment the wait counter; when it reaches MAX_WAIT, set ErrTimeout and go to IDLE with no redirect and no counter update.
REQ-020 RESOLVE: StallID=1; compare the captured 32-bit operands per the captured type, full-width, unsigned equality.
  - Taken: next state REDIRECT.
  - Not taken: next state IDLE.
  - ResolvedCount increments by 1 on exit from RESOLVE.
REQ-021 REDIRECT: StallID=1, PCSel=1, FlushIF=1, PCTarget=captured BrTarget; TakenCount increments by 1; next state IDLE.
REQ-022 Latency with operands ready at capture: taken branch, edge k capture, RESOLVE in cycle k+1, REDIRECT in cycle k+2, IDLE in cycle k+3. Not-taken branch returns to IDLE in cycle k+2.
REQ-023 PCSel and FlushIF SHALL be high only in REDIRECT, exactly one cycle per taken branch.
REQ-024 PCTarget SHALL hold its last value outside REDIRECT and SHALL be 0 after reset.
REQ-025 BrValid SHALL be ignored in any state other than IDLE; the branch is not captured or queued.
REQ-026 ExFlush=1 in any state SHALL force the next state to IDLE with no counter update.
  - ExFlush during REDIRECT: that cycle's pulses still occur, as they are Moore outputs.
  - ExFlush together with BrValid in IDLE: the branch is not captured.
REQ-027 Counters SHALL wrap from 16'hFFFF to 0.
REQ-028 ErrTimeout SHALL be cleared only by reset and SHALL not block further operation.

Reset
REQ-029 While rst_n=0 at a rising edge, the next state SHALL be:
  - state=IDLE;
  - PCSel=FlushIF=StallID=0 and BrAccept=1;
  - PCTarget, captured registers, wait counter, TakenCount, ResolvedCount and ErrTimeout all 0.
REQ-030 Reset asserted in any state, including mid-WAIT_OPS or REDIRECT, SHALL abandon the branch with no further pulse.

Verification
REQ-031 BEQ, Rs=Rt=0x1234, both Ready, target 0x00400040 -> PCSel/FlushIF high exactly in cycle k+2, PCTarget=0x00400040, TakenCount=1, ResolvedCount=1.
REQ-032 BNE, Rs=Rt=0xFFFFFFFF, both Ready -> no PCSel, IDLE at k+2, ResolvedCount=1, TakenCount=0.
REQ-033 BEQ, RtReady low 2 cycles then high with Rs=Rt=5, MAX_WAIT=4 -> StallID high 4 cycles total, then redirect pulse, ErrTimeout=0.
REQ-034 RsReady held low, MAX_WAIT=4 -> IDLE after 4 WAIT_OPS cycles, ErrTimeout=1 and stays 1, no PCSel, counters unchanged.
REQ-035 ExFlush asserted in RESOLVE of a taken branch -> no PCSel, IDLE next cycle, ResolvedCount unchanged; BrValid during stall ignored.
REQ-036 TakenCount preloaded via 65535 taken branches, then one more taken branch -> TakenCount=0; rst_n low mid-WAIT_OPS -> all outputs at reset values.

Source files
------------

// File: rtl/branch_ctrl.sv
// branch_ctrl: resolves one conditional branch (BEQ/BNE) at a time for the
// decode stage and issues a single-cycle PC redirect when it is taken.
//
// Handshake: a branch transfers on a rising edge where BrValid=1 and
// BrAccept=1 and ExFlush=0. BrAccept is high only in IDLE. BrValid seen in
// any other state is ignored, not queued. The producer must hold its
// branch until it sees the transfer.
//
// Ports
//   clk, rst_n             clock; synchronous active-low reset
//   BrValid, BrType        branch present; 0=BEQ, 1=BNE
//   BrTarget[31:0]         branch target address
//   RsReady/RtReady        operand valid (no pending producer)
//   RsData/RtData[31:0]    operand values, meaningful while Ready is high
//   ExFlush                pipeline squash, overrides everything else
//   BrAccept, StallID      idle/capture ready; hold decode stage
//   PCSel, FlushIF         one-cycle redirect pulse (REDIRECT state only)
//   PCTarget[31:0]         redirect address, held between redirects
//   TakenCount, ResolvedCount [CNT_W-1:0]  wrapping statistics counters
//   ErrTimeout             sticky operand-wait timeout flag
//   dbg_state[1:0]         current FSM state (IDLE=0 WAIT_OPS=1 RESOLVE=2 REDIRECT=3)
module branch_ctrl #(
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             BrValid,
    input  logic             BrType,
    input  logic [31:0]      BrTarget,
    input  logic             RsReady,
    input  logic             RtReady,
    input  logic [31:0]      RsData,
    input  logic [31:0]      RtData,
    input  logic             ExFlush,
    output logic             BrAccept,
    output logic             StallID,
    output logic             PCSel,
    output logic             FlushIF,
    output logic [31:0]      PCTarget,
    output logic [CNT_W-1:0] TakenCount,
    output logic [CNT_W-1:0] ResolvedCount,
    output logic             ErrTimeout,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_OPS = 2'd1,
        RESOLVE  = 2'd2,
        REDIRECT = 2'd3
    } state_t;

    // The wait counter increments once per non-ready WAIT_OPS cycle, so the
    // cycle in which it would reach MAX_WAIT is the one where it holds
    // MAX_WAIT-1; that cycle ends the wait.
    localparam logic [3:0]       WAIT_LAST = 4'(MAX_WAIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t             state;
    state_t             state_nxt;
    logic               br_type_q;
    logic [31:0]        br_target_q;
    logic [31:0]        rs_q;
    logic [31:0]        rt_q;
    logic [3:0]         wait_cnt;
    logic [31:0]        pc_target_q;
    logic [CNT_W-1:0]   taken_q;
    logic [CNT_W-1:0]   resolved_q;
    logic               err_q;

    logic               cap_br;
    logic               cap_ops;
    logic               clr_wait;
    logic               inc_wait;
    logic               set_err;
    logic               inc_resolved;
    logic               inc_taken;
    logic               load_pc;
    logic               ops_ready;
    logic               taken;

    assign ops_ready = RsReady & RtReady;
    assign taken     = br_type_q ? (rs_q != rt_q) : (rs_q == rt_q);

    // Next-state and datapath enables
    always_comb begin
        state_nxt    = state;
        cap_br       = 1'b0;
        cap_ops      = 1'b0;
        clr_wait     = 1'b0;
        inc_wait     = 1'b0;
        set_err      = 1'b0;
        inc_resolved = 1'b0;
        inc_taken    = 1'b0;
        load_pc      = 1'b0;

        case (state)
            IDLE: begin
                if (BrValid) begin
                    cap_br = 1'b1;
                    if (ops_ready) begin
                        cap_ops   = 1'b1;
                        state_nxt = RESOLVE;
                    end else begin
                        clr_wait  = 1'b1;
                        state_nxt = WAIT_OPS;
                    end
                end
            end
            WAIT_OPS: begin
                if (ops_ready) begin
                    cap_ops   = 1'b1;
                    state_nxt = RESOLVE;
                end else if (wait_cnt == WAIT_LAST) begin
                    set_err   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    inc_wait = 1'b1;
                end
            end
            RESOLVE: begin
                inc_resolved = 1'b1;
                if (taken) begin
                    load_pc   = 1'b1;
                    state_nxt = REDIRECT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            REDIRECT: begin
                inc_taken = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // A squash abandons whatever is in flight: no capture, no counting,
        // no timeout, straight back to IDLE.
        if (ExFlush) begin
            state_nxt    = IDLE;
            cap_br       = 1'b0;
            cap_ops      = 1'b0;
            clr_wait     = 1'b0;
            inc_wait     = 1'b0;
            set_err      = 1'b0;
            inc_resolved = 1'b0;
            inc_taken    = 1'b0;
            load_pc      = 1'b0;
        end
    end

    // Moore outputs decoded from the state
    always_comb begin
        BrAccept = 1'b0;
        StallID  = 1'b1;
        PCSel    = 1'b0;
        FlushIF  = 1'b0;
        case (state)
            IDLE: begin
                BrAccept = 1'b1;
                StallID  = 1'b0;
            end
            REDIRECT: begin
                PCSel   = 1'b1;
                FlushIF = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            br_type_q   <= 1'b0;
            br_target_q <= 32'd0;
            rs_q        <= 32'd0;
            rt_q        <= 32'd0;
            wait_cnt    <= 4'd0;
            pc_target_q <= 32'd0;
            taken_q     <= '0;
            resolved_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state <= state_nxt;
            if (cap_br) begin
                br_type_q   <= BrType;
                br_target_q <= BrTarget;
            end
            if (cap_ops) begin
                rs_q <= RsData;
                rt_q <= RtData;
            end
            if (clr_wait) begin
                wait_cnt <= 4'd0;
            end else if (inc_wait) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
            // PCTarget is loaded on entry to REDIRECT so it shows the
            // captured target for exactly the pulse cycle and holds after.
            if (load_pc) begin
                pc_target_q <= br_target_q;
            end
            if (inc_taken) begin
                taken_q <= taken_q + CNT_ONE;
            end
            if (inc_resolved) begin
                resolved_q <= resolved_q + CNT_ONE;
            end
            if (set_err) begin
                err_q <= 1'b1;
            end
        end
    end

    assign PCTarget      = pc_target_q;
    assign TakenCount    = taken_q;
    assign ResolvedCount = resolved_q;
    assign ErrTimeout    = err_q;
    assign dbg_state     = state;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed testbench for branch_ctrl. A second, narrow-counter instance is
// driven by the same stimulus so counter wrap can be seen in a short run.
module tb_branch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        BrValid;
    logic        BrType;
    logic [31:0] BrTarget;
    logic        RsReady;
    logic        RtReady;
    logic [31:0] RsData;
    logic [31:0] RtData;
    logic        ExFlush;
    logic        BrAccept;
    logic        StallID;
    logic        PCSel;
    logic        FlushIF;
    logic [31:0] PCTarget;
    logic [15:0] TakenCount;
    logic [15:0] ResolvedCount;
    logic        ErrTimeout;
    logic [1:0]  dbg_state;

    logic        s_accept;
    logic        s_stall;
    logic        s_pcsel;
    logic        s_flushif;
    logic [31:0] s_pctarget;
    logic [2:0]  s_taken;
    logic [2:0]  s_resolved;
    logic        s_err;
    logic [1:0]  s_state;

    int checks   = 0;
    int failures = 0;
    int stall_cycles;
    logic [15:0] exp_taken;
    logic [15:0] exp_resolved;
    logic [31:0] exp_q[$];

    branch_ctrl #(.MAX_WAIT(4)) dut (
        .clk(clk), .rst_n(rst_n), .BrValid(BrValid), .BrType(BrType),
        .BrTarget(BrTarget), .RsReady(RsReady), .RtReady(RtReady),
        .RsData(RsData), .RtData(RtData), .ExFlush(ExFlush),
        .BrAccept(BrAccept), .StallID(StallID), .PCSel(PCSel),
        .FlushIF(FlushIF), .PCTarget(PCTarget), .TakenCount(TakenCount),
        .ResolvedCount(ResolvedCount), .ErrTimeout(ErrTimeout),
        .dbg_state(dbg_state)
    );

    branch_ctrl #(.MAX_WAIT(4), .CNT_W(3)) dut_small (
        .clk(clk), .rst_n(rst_n), .BrValid(BrValid), .BrType(BrType),
        .BrTarget(BrTarget), .RsReady(RsReady), .RtReady(RtReady),
        .RsData(RsData), .RtData(RtData), .ExFlush(ExFlush),
        .BrAccept(s_accept), .StallID(s_stall), .PCSel(s_pcsel),
        .FlushIF(s_flushif), .PCTarget(s_pctarget), .TakenCount(s_taken),
        .ResolvedCount(s_resolved), .ErrTimeout(s_err),
        .dbg_state(s_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        BrValid  = 1'b0;
        BrType   = 1'b0;
        BrTarget = 32'hBAD0_0000;
        RsReady  = 1'b0;
        RtReady  = 1'b0;
        RsData   = 32'hDEAD_BEEF;
        RtData   = 32'h0BAD_F00D;
        ExFlush  = 1'b0;
    endtask

    task automatic drive_br(input logic typ, input logic [31:0] tgt,
                            input logic rsr, input logic rtr,
                            input logic [31:0] rs, input logic [31:0] rt);
        BrValid  = 1'b1;
        BrType   = typ;
        BrTarget = tgt;
        RsReady  = rsr;
        RtReady  = rtr;
        RsData   = rs;
        RtData   = rt;
        ExFlush  = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // ---------------- scoreboard: every redirect pulse must be expected ----------------
    always @(negedge clk) begin
        checks++;
        assert (FlushIF === PCSel) else begin
            failures++;
            $error("FAIL flushif_vs_pcsel observed=%0b expected=%0b", FlushIF, PCSel);
        end
        if (PCSel === 1'b1) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                failures++;
                $error("FAIL unexpected_pcsel observed=1 expected=0 target=%0h", PCTarget);
            end
            if (exp_q.size() > 0) begin
                logic [31:0] e;
                e = exp_q.pop_front();
                checks++;
                assert (PCTarget === e) else begin
                    failures++;
                    $error("FAIL redirect_target observed=%0h expected=%0h", PCTarget, e);
                end
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst_n = 1'b0;
        idle_inputs();
        exp_taken    = 16'd0;
        exp_resolved = 16'd0;
        tick();
        tick();
        chk("rst_accept", BrAccept, 1);
        chk("rst_stall", StallID, 0);
        chk("rst_pcsel", PCSel, 0);
        chk("rst_flushif", FlushIF, 0);
        chk("rst_pctarget", PCTarget, 0);
        chk("rst_taken", TakenCount, 0);
        chk("rst_resolved", ResolvedCount, 0);
        chk("rst_err", ErrTimeout, 0);
        chk("rst_state", dbg_state, 0);
        rst_n = 1'b1;
        tick();

        // BEQ taken, operands ready at capture
        drive_br(1'b0, 32'h0040_0040, 1'b1, 1'b1, 32'h1234, 32'h1234);
        tick();
        idle_inputs();
        chk("t1_k1_state", dbg_state, 2);
        chk("t1_k1_stall", StallID, 1);
        chk("t1_k1_accept", BrAccept, 0);
        chk("t1_k1_pcsel", PCSel, 0);
        exp_q.push_back(32'h0040_0040);
        exp_resolved++;
        tick();
        chk("t1_k2_pcsel", PCSel, 1);
        chk("t1_k2_flushif", FlushIF, 1);
        chk("t1_k2_pctarget", PCTarget, 32'h0040_0040);
        chk("t1_k2_resolved", ResolvedCount, 1);
        exp_taken++;
        tick();
        chk("t1_k3_state", dbg_state, 0);
        chk("t1_k3_pcsel", PCSel, 0);
        chk("t1_k3_taken", TakenCount, 1);
        chk("t1_k3_pctarget_hold", PCTarget, 32'h0040_0040);

        // BNE with equal all-ones operands: not taken
        drive_br(1'b1, 32'h0050_0000, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        tick();
        idle_inputs();
        chk("t2_k1_state", dbg_state, 2);
        exp_resolved++;
        tick();
        chk("t2_k2_state", dbg_state, 0);
        chk("t2_k2_accept", BrAccept, 1);
        chk("t2_resolved", ResolvedCount, 2);
        chk("t2_taken", TakenCount, 1);

        // BNE differing only in bit 31: taken
        drive_br(1'b1, 32'h0000_1000, 1'b1, 1'b1, 32'h8000_0000, 32'h0000_0000);
        tick();
        idle_inputs();
        exp_q.push_back(32'h0000_1000);
        exp_resolved++;
        tick();
        chk("t2b_pcsel", PCSel, 1);
        chk("t2b_pctarget", PCTarget, 32'h0000_1000);
        exp_taken++;
        tick();
        chk("t2b_taken", TakenCount, 2);

        // BEQ differing only in bit 0: not taken, PCTarget holds
        drive_br(1'b0, 32'h0000_2000, 1'b1, 1'b1, 32'h0000_0001, 32'h0000_0000);
        tick();
        idle_inputs();
        exp_resolved++;
        tick();
        chk("t2c_state", dbg_state, 0);
        chk("t2c_pctarget_hold", PCTarget, 32'h0000_1000);
        chk("t2c_resolved", ResolvedCount, 4);

        // BEQ, RtReady low for the capture cycle and one wait cycle;
        // a second BrValid during the stall must be ignored.
        drive_br(1'b0, 32'h0040_0100, 1'b1, 1'b0, 32'h5, 32'h7);
        tick();
        stall_cycles = 0;
        stall_cycles += int'(StallID);
        chk("t3_w1_state", dbg_state, 1);
        chk("t3_w1_accept", BrAccept, 0);
        BrTarget = 32'h0BAD_0BAD;
        tick();
        stall_cycles += int'(StallID);
        chk("t3_w2_state", dbg_state, 1);
        RtReady = 1'b1;
        RtData  = 32'h5;
        RsData  = 32'h5;
        tick();
        stall_cycles += int'(StallID);
        chk("t3_resolve_state", dbg_state, 2);
        idle_inputs();
        exp_q.push_back(32'h0040_0100);
        exp_resolved++;
        tick();
        stall_cycles += int'(StallID);
        chk("t3_pcsel", PCSel, 1);
        chk("t3_pctarget", PCTarget, 32'h0040_0100);
        exp_taken++;
        tick();
        stall_cycles += int'(StallID);
        chk("t3_stall_cycles", stall_cycles, 4);
        chk("t3_err", ErrTimeout, 0);
        chk("t3_taken", TakenCount, 3);

        // RsReady held low: timeout after 4 wait cycles
        drive_br(1'b0, 32'h0060_0000, 1'b0, 1'b1, 32'h1, 32'h1);
        tick();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            chk("t4_waiting", dbg_state, 1);
            tick();
        end
        chk("t4_w4_state", dbg_state, 1);
        chk("t4_w4_err", ErrTimeout, 0);
        tick();
        chk("t4_idle", dbg_state, 0);
        chk("t4_err_set", ErrTimeout, 1);
        chk("t4_taken", TakenCount, 3);
        chk("t4_resolved", ResolvedCount, 5);

        // ExFlush in RESOLVE of a taken branch; BrValid during stall ignored
        drive_br(1'b0, 32'hDEAD_0000, 1'b1, 1'b1, 32'h9, 32'h9);
        tick();
        chk("t5_resolve", dbg_state, 2);
        drive_br(1'b0, 32'h0BAD_0000, 1'b1, 1'b1, 32'h3, 32'h3);
        ExFlush = 1'b1;
        tick();
        idle_inputs();
        chk("t5_idle", dbg_state, 0);
        chk("t5_resolved", ResolvedCount, 5);
        tick();
        chk("t5_not_captured", dbg_state, 0);
        chk("t5_err_sticky", ErrTimeout, 1);

        // ExFlush together with BrValid in IDLE: not captured
        drive_br(1'b0, 32'h0BAD_1111, 1'b1, 1'b1, 32'h3, 32'h3);
        ExFlush = 1'b1;
        tick();
        idle_inputs();
        chk("t5b_state", dbg_state, 0);
        chk("t5b_accept", BrAccept, 1);

        // ExFlush during REDIRECT: pulse still seen, no taken count
        drive_br(1'b1, 32'h0070_0000, 1'b1, 1'b1, 32'h1, 32'h2);
        tick();
        idle_inputs();
        exp_q.push_back(32'h0070_0000);
        exp_resolved++;
        tick();
        chk("t6_pcsel", PCSel, 1);
        ExFlush = 1'b1;
        tick();
        ExFlush = 1'b0;
        chk("t6_idle", dbg_state, 0);
        chk("t6_taken", TakenCount, 3);
        chk("t6_resolved", ResolvedCount, 6);

        // Back-to-back taken branches, enough to wrap the narrow counters
        for (int i = 0; i < 5; i++) begin
            drive_br(1'b0, 32'h0000_2000 + 32'(i * 16), 1'b1, 1'b1, 32'(i), 32'(i));
            tick();
            idle_inputs();
            exp_q.push_back(32'h0000_2000 + 32'(i * 16));
            exp_resolved++;
            tick();
            chk("t7_pcsel", PCSel, 1);
            exp_taken++;
            tick();
        end
        chk("t7_taken", TakenCount, 8);
        chk("t7_taken_model", TakenCount, exp_taken);
        chk("t7_resolved", ResolvedCount, 11);
        chk("t7_resolved_model", ResolvedCount, exp_resolved);
        chk("t7_small_taken_wrap", s_taken, 0);
        chk("t7_small_resolved_wrap", s_resolved, 3);

        // Reset mid-WAIT_OPS
        drive_br(1'b0, 32'h0080_0000, 1'b0, 1'b0, 32'h1, 32'h1);
        tick();
        chk("t8_wait", dbg_state, 1);
        idle_inputs();
        rst_n = 1'b0;
        tick();
        chk("t8_state", dbg_state, 0);
        chk("t8_accept", BrAccept, 1);
        chk("t8_stall", StallID, 0);
        chk("t8_pcsel", PCSel, 0);
        chk("t8_flushif", FlushIF, 0);
        chk("t8_pctarget", PCTarget, 0);
        chk("t8_taken", TakenCount, 0);
        chk("t8_resolved", ResolvedCount, 0);
        chk("t8_err", ErrTimeout, 0);
        rst_n = 1'b1;
        exp_taken    = 16'd0;
        exp_resolved = 16'd0;
        tick();

        // Reset in RESOLVE of a taken branch: no redirect afterwards
        drive_br(1'b0, 32'h0090_0000, 1'b1, 1'b1, 32'h3, 32'h3);
        tick();
        chk("t9_resolve", dbg_state, 2);
        idle_inputs();
        rst_n = 1'b0;
        tick();
        chk("t9_state", dbg_state, 0);
        chk("t9_pcsel", PCSel, 0);
        rst_n = 1'b1;
        tick();
        chk("t9_pcsel_after", PCSel, 0);
        chk("t9_pctarget", PCTarget, 0);
        chk("t9_resolved", ResolvedCount, 0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
